lcd_frame_reader: RTL and testbench
===================================

Name: lcd_frame_reader

Overview:
- Display-side counterpart of the camera write path: pops paired 16-bit words from the two SDRAM read-port FIFOs and unpacks them into 10-bit R/G/B.
- Generates LCD timing (hsync, vsync, data-enable) for an 800x480 panel.
- Issues a per-frame start pulse so the SDRAM controller reloads its read address.
- Sits between the SDRAM controller read FIFOs and the LCD pads.

Parameters:
H_ACTIVE, 800, visible pixels per line
H_FRONT, 40, front-porch clocks
H_SYNC, 1, hsync width in clocks
H_BACK, 215, back-porch clocks (line total 1056)
V_ACTIVE, 480, visible lines per frame
V_FRONT, 10, front-porch lines
V_SYNC, 1, vsync width in lines
V_BACK, 34, back-porch lines (frame total 525)

Ports:
iClk  in  1  pixel clock
iRst_n  in  1  asynchronous active-low reset
iEnable  in  1  display enable; sampled only at frame boundaries
iRd1_data  in  16  read FIFO 1 word {0, G[11:7], B[11:2]}
iRd2_data  in  16  read FIFO 2 word {0, G[6:2], R[11:2]}
iRd_empty  in  1  either read FIFO empty
oRd_req  out  1  read strobe to both FIFOs (FIFO data appears 1 clock later; no show-ahead)
oFrame_start  out  1  one-clock pulse at start of each frame
oLCD_R  out  10  red
oLCD_G  out  10  green
oLCD_B  out  10  blue
oLCD_HS  out  1  hsync, active low
oLCD_VS  out  1  vsync, active low
oLCD_DE  out  1  data enable, active high
oUnderflow  out  1  sticky underflow flag, cleared at oFrame_start

Behaviour:
- Reset, asynchronous, active low: FSM=IDLE, counters=0, oRd_req=0, oFrame_start=0, RGB=0, oLCD_HS=1, oLCD_VS=1, oLCD_DE=0, oUnderflow=0.
- Counters:
  - hcnt runs 0..H_TOTAL-1; line order is sync, back porch, active, front porch.
  - vcnt increments when hcnt wraps; frame order is the same.
  - Active when hcnt is in [H_SYNC+H_BACK, H_SYNC+H_BACK+H_ACTIVE) and the same rule holds for vcnt.
- FSM:
  - IDLE: counters held at 0, outputs blank, HS/VS high. Move to RUN when iEnable=1 and iRd_empty=0. On entry, oFrame_start pulses for 1 clock.
  - RUN: counters free-run. At the final count (hcnt=H_TOTAL-1, vcnt=V_TOTAL-1):
    - if iEnable=1, wrap and pulse oFrame_start;
    - else go to IDLE.
  - iEnable dropping mid-frame always completes the current frame.
- Pipeline, stage 0 to stage 2:
  - Stage 0: oRd_req = RUN & active(hcnt,vcnt) & !iRd_empty (combinational from registered counters).
  - Stage 1: FIFO data valid.
  - Stage 2: registered RGB output.
  - HS, VS and DE are delayed by 2 registers so that oLCD_DE rises exactly 2 clocks after the first oRd_req of a line.
- Unpack, at stage 1 into registers:
  - R = iRd2_data[9:0]
  - B = iRd1_data[9:0]
  - G = {iRd1_data[14:10], iRd2_data[14:10]}
  - Bit 15 of both words is ignored.
- Blanking: RGB=0 whenever the delayed DE is 0.
- Underflow:
  - An active pixel with iRd_empty=1 suppresses oRd_req; that pixel is output as 0 with DE still 1.
  - oUnderflow is set and stays set until the next oFrame_start.
  - Pixel count per frame is never stretched; timing always wins.
- Same clock as oFrame_start and an underflow: the clear has priority.

Decomposition:
- Shared package (lcd_timing_pkg) holds the default timing constants, derived totals (H_TOTAL, V_TOTAL) and the RGB packing bit positions. The packing positions are shared with the writer-side arbitrator.
- One natural sub-module: lcd_timing_gen (counters, active/sync decode, frame-end strobe).
- This block owns the FSM, read strobe, unpack pipeline and underflow logic.

Test Plan:
- Reset mid-RUN (iRst_n low for 3 clocks at hcnt=500) -> all outputs at reset values immediately; IDLE after release; oFrame_start only once iEnable=1 and FIFO non-empty.
- Unpack: rd1=16'h7FFF, rd2=16'h0000 -> R=0, G=10'h3E0, B=10'h3FF, appearing 2 clocks after the oRd_req.
- Unpack: rd1=16'h0000, rd2=16'h7FFF -> R=10'h3FF, G=10'h01F, B=0.
- Timing (defaults, FIFO never empty):
  - 800 oRd_req per line and 384000 per frame;
  - HS low 1 clock per 1056; VS low 1056 clocks per 525x1056;
  - first DE at hcnt=218.
- Underflow: iRd_empty=1 for 5 active clocks -> no oRd_req and RGB=0 with DE=1 for those 5 pixels; oUnderflow=1 until next oFrame_start, then 0.
- iEnable dropped at vcnt=100 -> frame completes to vcnt=524 and hcnt=1055, then IDLE with no further oFrame_start.

Source files
------------

// File: rtl/lcd_timing_pkg.sv
// Shared LCD timing and pixel-packing definitions.
// Holds the default 800x480 panel timing, the derived line/frame totals,
// the bit positions used to pack 30-bit RGB into two 16-bit SDRAM words
// (shared with the writer-side arbitrator), the reader FSM state type and
// the unpack helper.
package lcd_timing_pkg;

  // Default panel timing (line order and frame order: sync, back porch, active, front porch)
  localparam int LCD_H_ACTIVE = 800;
  localparam int LCD_H_FRONT  = 40;
  localparam int LCD_H_SYNC   = 1;
  localparam int LCD_H_BACK   = 215;
  localparam int LCD_V_ACTIVE = 480;
  localparam int LCD_V_FRONT  = 10;
  localparam int LCD_V_SYNC   = 1;
  localparam int LCD_V_BACK   = 34;
  localparam int LCD_H_TOTAL  = LCD_H_SYNC + LCD_H_BACK + LCD_H_ACTIVE + LCD_H_FRONT;
  localparam int LCD_V_TOTAL  = LCD_V_SYNC + LCD_V_BACK + LCD_V_ACTIVE + LCD_V_FRONT;

  // Packing: word1 = {pad, G[11:7], B[11:2]}, word2 = {pad, G[6:2], R[11:2]}
  localparam int PK_WORD_W    = 16;
  localparam int PK_COLOR_W   = 10;
  localparam int PK_COLOR_LSB = 0;
  localparam int PK_G_LSB     = 10;
  localparam int PK_G_W       = 5;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } rd_state_t;

  typedef struct packed {
    logic [PK_COLOR_W-1:0] r;
    logic [PK_COLOR_W-1:0] g;
    logic [PK_COLOR_W-1:0] b;
  } rgb_t;

  localparam rgb_t RGB_BLANK = '{r: 10'h000, g: 10'h000, b: 10'h000};

  // Split a word pair back into R/G/B; the pad bit is not passed in.
  function automatic rgb_t lcd_unpack(input logic [PK_WORD_W-2:0] rd1,
                                      input logic [PK_WORD_W-2:0] rd2);
    rgb_t px;
    px.r = rd2[PK_COLOR_LSB +: PK_COLOR_W];
    px.b = rd1[PK_COLOR_LSB +: PK_COLOR_W];
    px.g = {rd1[PK_G_LSB +: PK_G_W], rd2[PK_G_LSB +: PK_G_W]};
    return px;
  endfunction

endpackage

// File: rtl/lcd_timing_gen.sv
// LCD raster counters.
// Ports:
//   i_clk, i_rst_n  pixel clock, async active-low reset
//   i_run           advance counters; when low they hold (they rest at 0)
//   o_active        current position is inside the visible window
//   o_hsync_zone    current column is inside the hsync interval
//   o_vsync_zone    current line is inside the vsync interval
//   o_frame_end     last clock of the frame (hcnt, vcnt both at their final count)
module lcd_timing_gen #(
  parameter int H_ACTIVE = 800,
  parameter int H_FRONT  = 40,
  parameter int H_SYNC   = 1,
  parameter int H_BACK   = 215,
  parameter int V_ACTIVE = 480,
  parameter int V_FRONT  = 10,
  parameter int V_SYNC   = 1,
  parameter int V_BACK   = 34
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_run,
  output logic o_active,
  output logic o_hsync_zone,
  output logic o_vsync_zone,
  output logic o_frame_end
);

  localparam int H_TOTAL = H_SYNC + H_BACK + H_ACTIVE + H_FRONT;
  localparam int V_TOTAL = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;
  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);

  localparam logic [HW-1:0] H_LAST  = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_SEND  = HW'(H_SYNC);
  localparam logic [HW-1:0] H_ABEG  = HW'(H_SYNC + H_BACK);
  localparam logic [HW-1:0] H_AEND  = HW'(H_SYNC + H_BACK + H_ACTIVE);
  localparam logic [HW-1:0] H_ONE   = HW'(1);
  localparam logic [VW-1:0] V_LAST  = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_SEND  = VW'(V_SYNC);
  localparam logic [VW-1:0] V_ABEG  = VW'(V_SYNC + V_BACK);
  localparam logic [VW-1:0] V_AEND  = VW'(V_SYNC + V_BACK + V_ACTIVE);
  localparam logic [VW-1:0] V_ONE   = VW'(1);

  logic [HW-1:0] r_hcnt;
  logic [VW-1:0] r_vcnt;
  logic          w_h_last;
  logic          w_v_last;

  assign w_h_last     = (r_hcnt == H_LAST);
  assign w_v_last     = (r_vcnt == V_LAST);
  assign o_frame_end  = w_h_last & w_v_last;
  assign o_hsync_zone = (r_hcnt < H_SEND);
  assign o_vsync_zone = (r_vcnt < V_SEND);
  assign o_active     = (r_hcnt >= H_ABEG) && (r_hcnt < H_AEND) &&
                        (r_vcnt >= V_ABEG) && (r_vcnt < V_AEND);

  // Raster counters; vcnt steps when hcnt wraps, both wrap together at frame end.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_hcnt <= {HW{1'b0}};
      r_vcnt <= {VW{1'b0}};
    end else if (i_run) begin
      if (w_h_last) begin
        r_hcnt <= {HW{1'b0}};
        r_vcnt <= w_v_last ? {VW{1'b0}} : (r_vcnt + V_ONE);
      end else begin
        r_hcnt <= r_hcnt + H_ONE;
      end
    end
  end

endmodule

// File: rtl/lcd_frame_reader.sv
// LCD frame reader: pops word pairs from the two SDRAM read FIFOs, unpacks
// them to 10-bit RGB and drives 800x480 panel timing.
// Ports:
//   iClk, iRst_n            pixel clock, async active-low reset
//   iEnable                 display enable, only looked at on frame boundaries
//   iRd1_data, iRd2_data    FIFO words, valid the clock after oRd_req
//   iRd_empty               either FIFO empty
//   oRd_req                 read strobe to both FIFOs
//   oFrame_start            one-clock pulse on the first clock of every frame
//   oLCD_R/G/B              pixel data, zero outside data-enable
//   oLCD_HS, oLCD_VS        syncs, active low
//   oLCD_DE                 data enable, active high
//   oUnderflow              sticky starvation flag, cleared by oFrame_start
module lcd_frame_reader
  import lcd_timing_pkg::*;
#(
  parameter int H_ACTIVE = LCD_H_ACTIVE,
  parameter int H_FRONT  = LCD_H_FRONT,
  parameter int H_SYNC   = LCD_H_SYNC,
  parameter int H_BACK   = LCD_H_BACK,
  parameter int V_ACTIVE = LCD_V_ACTIVE,
  parameter int V_FRONT  = LCD_V_FRONT,
  parameter int V_SYNC   = LCD_V_SYNC,
  parameter int V_BACK   = LCD_V_BACK
) (
  input  logic        iClk,
  input  logic        iRst_n,
  input  logic        iEnable,
  input  logic [15:0] iRd1_data,
  input  logic [15:0] iRd2_data,
  input  logic        iRd_empty,
  output logic        oRd_req,
  output logic        oFrame_start,
  output logic [9:0]  oLCD_R,
  output logic [9:0]  oLCD_G,
  output logic [9:0]  oLCD_B,
  output logic        oLCD_HS,
  output logic        oLCD_VS,
  output logic        oLCD_DE,
  output logic        oUnderflow
);

  rd_state_t r_state;
  logic      r_frame_start;
  logic      w_active, w_hsync_zone, w_vsync_zone, w_frame_end;
  logic      w_run, w_pix, w_start;
  logic      r_de1, r_req1, r_hs1, r_vs1;
  logic      r_de2, r_hs2, r_vs2;
  logic      r_underflow;
  rgb_t      r_rgb;
  logic      w_unused;

  lcd_timing_gen #(
    .H_ACTIVE(H_ACTIVE), .H_FRONT(H_FRONT), .H_SYNC(H_SYNC), .H_BACK(H_BACK),
    .V_ACTIVE(V_ACTIVE), .V_FRONT(V_FRONT), .V_SYNC(V_SYNC), .V_BACK(V_BACK)
  ) u_timing (
    .i_clk        (iClk),
    .i_rst_n      (iRst_n),
    .i_run        (w_run),
    .o_active     (w_active),
    .o_hsync_zone (w_hsync_zone),
    .o_vsync_zone (w_vsync_zone),
    .o_frame_end  (w_frame_end)
  );

  // The pad bit of each word carries nothing.
  assign w_unused = iRd1_data[15] ^ iRd2_data[15];

  assign w_run   = (r_state == ST_RUN);
  assign w_pix   = w_run & w_active;
  // A starved pixel is skipped rather than stalled: timing never waits for data.
  assign oRd_req = w_pix & ~iRd_empty;

  // Frame start: leave idle once enabled with data waiting, or wrap a running frame while still enabled.
  always_comb begin
    w_start = 1'b0;
    case (r_state)
      ST_IDLE: w_start = iEnable & ~iRd_empty;
      ST_RUN:  w_start = w_frame_end & iEnable;
      default: w_start = 1'b0;
    endcase
  end

  // Reader FSM with the registered frame-start pulse; a disabled display still finishes its frame.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      r_state       <= ST_IDLE;
      r_frame_start <= 1'b0;
    end else begin
      r_frame_start <= w_start;
      case (r_state)
        ST_IDLE: if (w_start) r_state <= ST_RUN;
        ST_RUN:  if (w_frame_end && !iEnable) r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Two-stage pipeline: stage 1 waits for FIFO data, stage 2 holds the unpacked pixel and delayed syncs/DE.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      r_de1 <= 1'b0;
      r_req1 <= 1'b0;
      r_hs1 <= 1'b1;
      r_vs1 <= 1'b1;
      r_de2 <= 1'b0;
      r_hs2 <= 1'b1;
      r_vs2 <= 1'b1;
      r_rgb <= RGB_BLANK;
    end else begin
      r_de1  <= w_pix;
      r_req1 <= oRd_req;
      r_hs1  <= ~(w_run & w_hsync_zone);
      r_vs1  <= ~(w_run & w_vsync_zone);
      r_de2  <= r_de1;
      r_hs2  <= r_hs1;
      r_vs2  <= r_vs1;
      // Blank outside DE and on starved pixels (no word was popped for them).
      if (r_de1 && r_req1) begin
        r_rgb <= lcd_unpack(iRd1_data[14:0], iRd2_data[14:0]);
      end else begin
        r_rgb <= RGB_BLANK;
      end
    end
  end

  // Sticky underflow; the clear at frame start wins over a same-clock set.
  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      r_underflow <= 1'b0;
    end else if (w_start) begin
      r_underflow <= 1'b0;
    end else if (w_pix && iRd_empty) begin
      r_underflow <= 1'b1;
    end
  end

  assign oFrame_start = r_frame_start;
  assign oLCD_R       = r_rgb.r;
  assign oLCD_G       = r_rgb.g;
  assign oLCD_B       = r_rgb.b;
  assign oLCD_HS      = r_hs2;
  assign oLCD_VS      = r_vs2;
  assign oLCD_DE      = r_de2;
  assign oUnderflow   = r_underflow;

endmodule

// File: tb/tb_lcd_frame_reader.sv
// Bench for lcd_frame_reader. Horizontal timing is the real 1056-clock line;
// the vertical is shrunk to 9 lines so several whole frames fit in the run.
module tb_lcd_frame_reader;

  localparam int H_ACTIVE = 800, H_FRONT = 40, H_SYNC = 1, H_BACK = 215;
  localparam int V_ACTIVE = 4, V_FRONT = 2, V_SYNC = 1, V_BACK = 2;
  localparam int HT  = H_SYNC + H_BACK + H_ACTIVE + H_FRONT;
  localparam int VT  = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;
  localparam int FT  = HT * VT;
  localparam int HA0 = H_SYNC + H_BACK;
  localparam int VA0 = V_SYNC + V_BACK;

  logic        iClk = 1'b0;
  logic        iRst_n, iEnable, iRd_empty;
  logic [15:0] iRd1_data, iRd2_data;
  logic        oRd_req, oFrame_start, oLCD_HS, oLCD_VS, oLCD_DE, oUnderflow;
  logic [9:0]  oLCD_R, oLCD_G, oLCD_B;

  always #5 iClk = ~iClk;

  lcd_frame_reader #(
    .H_ACTIVE(H_ACTIVE), .H_FRONT(H_FRONT), .H_SYNC(H_SYNC), .H_BACK(H_BACK),
    .V_ACTIVE(V_ACTIVE), .V_FRONT(V_FRONT), .V_SYNC(V_SYNC), .V_BACK(V_BACK)
  ) dut (
    .iClk(iClk), .iRst_n(iRst_n), .iEnable(iEnable),
    .iRd1_data(iRd1_data), .iRd2_data(iRd2_data), .iRd_empty(iRd_empty),
    .oRd_req(oRd_req), .oFrame_start(oFrame_start),
    .oLCD_R(oLCD_R), .oLCD_G(oLCD_G), .oLCD_B(oLCD_B),
    .oLCD_HS(oLCD_HS), .oLCD_VS(oLCD_VS), .oLCD_DE(oLCD_DE),
    .oUnderflow(oUnderflow)
  );

  int checks = 0;
  int failures = 0;

  // scenario controls
  logic c_rst_n = 1'b0, c_en = 1'b0, c_empty = 1'b1;

  // FIFO emulation
  int fifo_idx = 0;
  bit pop_prev = 1'b0;

  // behavioural model: frame position plus 2-deep output history
  typedef struct {
    bit          act;
    bit          req;
    bit          hs;
    bit          vs;
    logic [29:0] pix;
  } hist_t;
  bit    m_run = 1'b0;
  int    m_pos = 0;
  bit    m_fs = 1'b0;
  bit    m_uf = 1'b0;
  int    m_pops = 0;
  hist_t h1, h2;

  // statistics
  int fs_total = 0, fr_req = 0, fr_hs = 0, fr_vs = 0, line_req = 0, cyc_since_fs = 0;
  bit cnt_valid = 1'b0, uf_frame = 1'b0, line_uf = 1'b0;
  int pin_stage = 0;

  function automatic logic [15:0] word1(input int k);
    if (k == 0) return 16'h7FFF;
    else if (k == 1) return 16'h0000;
    else return 16'(k * 4951 + 33825);
  endfunction

  function automatic logic [15:0] word2(input int k);
    if (k == 0) return 16'h0000;
    else if (k == 1) return 16'h7FFF;
    else return 16'((k * 741) ^ 42435);
  endfunction

  // Expected {R,G,B} for the k-th popped pair, from the packing rule.
  function automatic logic [29:0] exp_pix(input int k);
    int a, b, r, g, bl;
    a = int'(word1(k));
    b = int'(word2(k));
    r  = b % 1024;
    bl = a % 1024;
    g  = ((a / 1024) % 32) * 32 + ((b / 1024) % 32);
    return {r[9:0], g[9:0], bl[9:0]};
  endfunction

  task automatic chk(input string name, input int got, input int expv);
    checks++;
    if (got != expv) begin
      failures++;
      $display("FAIL %s got=%0d required=%0d", name, got, expv);
    end
  endtask

  task automatic model_reset();
    m_run = 1'b0; m_pos = 0; m_fs = 1'b0; m_uf = 1'b0;
    h1.act = 1'b0; h1.req = 1'b0; h1.hs = 1'b1; h1.vs = 1'b1; h1.pix = 30'h0;
    h2 = h1;
    cnt_valid = 1'b0; line_req = 0; line_uf = 1'b0;
  endtask

  task automatic cycle();
    hist_t       cur;
    bit          start, act, ereq;
    int          h, v;
    logic [29:0] got, exp_rgb;
    @(negedge iClk);
    if (pop_prev) begin
      iRd1_data = word1(fifo_idx);
      iRd2_data = word2(fifo_idx);
      fifo_idx++;
    end
    iRst_n = c_rst_n; iEnable = c_en; iRd_empty = c_empty;
    if (!c_rst_n) model_reset();
    #1;
    h = m_pos % HT;
    v = m_pos / HT;
    act  = m_run && h >= HA0 && h < HA0 + H_ACTIVE && v >= VA0 && v < VA0 + V_ACTIVE;
    ereq = act && !c_empty;
    exp_rgb = h2.req ? h2.pix : 30'h0;
    got = {oLCD_R, oLCD_G, oLCD_B};
    checks++;
    if (oRd_req !== ereq || oFrame_start !== m_fs || oLCD_DE !== h2.act || oLCD_HS !== h2.hs ||
        oLCD_VS !== h2.vs || oUnderflow !== m_uf || got !== exp_rgb) begin
      failures++;
      $display("FAIL cycle_compare t=%0t pos=%0d got req=%b fs=%b de=%b hs=%b vs=%b uf=%b rgb=%h required req=%b fs=%b de=%b hs=%b vs=%b uf=%b rgb=%h",
               $time, m_pos, oRd_req, oFrame_start, oLCD_DE, oLCD_HS, oLCD_VS, oUnderflow, got,
               ereq, m_fs, h2.act, h2.hs, h2.vs, m_uf, exp_rgb);
    end
    // frame / line statistics against literal expectations
    if (oFrame_start === 1'b1) begin
      fs_total++;
      chk("uf_clear_at_start", int'(oUnderflow), 0);
      if (cnt_valid) begin
        chk("frame_req", fr_req, uf_frame ? 3195 : 3200);
        chk("frame_hs_low", fr_hs, 9);
        chk("frame_vs_low", fr_vs, 1056);
      end
      uf_frame = 1'b0; cnt_valid = 1'b1; fr_req = 0; fr_hs = 0; fr_vs = 0; cyc_since_fs = 0;
    end else begin
      cyc_since_fs++;
    end
    if (oRd_req === 1'b1) begin fr_req++; line_req++; end
    if (oLCD_HS === 1'b0) begin
      fr_hs++;
      if (line_req > 0) begin
        chk("line_req", line_req, line_uf ? 795 : 800);
        line_req = 0; line_uf = 1'b0;
      end
    end
    if (oLCD_VS === 1'b0) fr_vs++;
    if (pin_stage == 2) begin
      chk("unpack_rd2_ones", int'(got), int'({10'h3FF, 10'h01F, 10'h000}));
      pin_stage = 0;
    end
    if (pin_stage == 1 && oLCD_DE === 1'b1) begin
      chk("first_de_offset", cyc_since_fs, 3386);   // line 3, hcnt 218
      chk("unpack_rd1_ones", int'(got), int'({10'h000, 10'h3E0, 10'h3FF}));
      pin_stage = 2;
    end
    pop_prev = (oRd_req === 1'b1);
    // advance the model to the next clock
    if (c_rst_n) begin
      start = (!m_run && c_en && !c_empty) || (m_run && m_pos == FT - 1 && c_en);
      cur.act = act; cur.req = ereq;
      cur.hs = !(m_run && h < H_SYNC); cur.vs = !(m_run && v < V_SYNC);
      cur.pix = exp_pix(m_pops);
      h2 = h1; h1 = cur;
      if (ereq) m_pops++;
      if (start) m_uf = 1'b0;
      else if (act && c_empty) m_uf = 1'b1;
      m_fs = start;
      if (!m_run) begin
        if (start) begin m_run = 1'b1; m_pos = 0; end
      end else if (m_pos == FT - 1) begin
        m_pos = 0; m_run = c_en;
      end else begin
        m_pos++;
      end
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic run_to(input int pos, input int limit);
    int n;
    n = 0;
    while (!(m_run && m_pos == pos) && n < limit) begin
      cycle();
      n++;
    end
    checks++;
    if (!(m_run && m_pos == pos)) begin
      failures++;
      $display("FAIL run_to_timeout got pos=%0d required pos=%0d", m_pos, pos);
    end
  endtask

  initial begin
    iRst_n = 1'b1; iEnable = 1'b0; iRd_empty = 1'b1; iRd1_data = 16'h0; iRd2_data = 16'h0;
    // power-on reset, then idle while disabled
    c_rst_n = 1'b0; run(3);
    c_rst_n = 1'b1; run(20);
    c_empty = 1'b0; run(10);
    chk("no_start_while_disabled", fs_total, 0);
    // start a frame, reset it mid-line at hcnt=500
    c_en = 1'b1;
    run_to(1 * HT + 500, 5000);
    c_rst_n = 1'b0; run(3);
    c_rst_n = 1'b1;
    c_empty = 1'b1; run(50);
    chk("no_start_while_empty", fs_total, 1);
    // frame A: clean, pins first DE and the unpack patterns
    c_empty = 1'b0; pin_stage = 1;
    run_to(FT - 1, FT + 100);
    cycle();
    // frame B: 5 starved active pixels on line 4
    run_to(4 * HT + 300, FT);
    c_empty = 1'b1; uf_frame = 1'b1; line_uf = 1'b1;
    run(5);
    c_empty = 1'b0;
    run(100);
    chk("underflow_sticky", int'(oUnderflow), 1);
    run_to(FT - 1, FT);
    cycle();
    // frame C: disable at line 5, frame must complete and then stay idle
    run_to(5 * HT, FT);
    c_en = 1'b0;
    run(FT - 5 * HT + 2000);
    chk("frame_req_last", fr_req, 3200);
    chk("frame_hs_low_last", fr_hs, 9);
    chk("frame_vs_low_last", fr_vs, 1056);
    chk("frame_start_total", fs_total, 4);
    chk("unpack_pins_seen", pin_stage, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
